// File: rtl/mux_scan_n.sv
// mux_scan_n: N-channel, WIDTH-bit multiplexer with a registered output.
// Manual mode selects the channel from sel_in; scan mode walks a round-robin
// pointer over every channel, holding DWELL enabled cycles on each. Every
// scan episode restarts at channel 0 with a full dwell.
module mux_scan_n #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = 2,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel_in,
  input  logic                 en,
  output logic [WIDTH-1:0]     dout,
  output logic [SELW-1:0]      dout_ch,
  output logic                 dout_valid,
  output logic                 scan_wrap
);

  localparam int              CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SELW-1:0] LAST_CH  = SELW'(NCH - 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DWELL - 1);

  logic [WIDTH-1:0] r_dout;
  logic [SELW-1:0]  r_dout_ch;
  logic             r_dout_valid;
  logic             r_scan_wrap;
  logic [SELW-1:0]  r_ptr;
  logic [CNTW-1:0]  r_dwell_cnt;
  logic             r_mode_q;

  logic [WIDTH-1:0] w_ch_data [NCH];
  logic             w_entry;
  logic             w_in_range;
  logic [SELW-1:0]  w_idx;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_last_dwell;
  logic             w_last_ch;
  logic [SELW-1:0]  w_ptr_next;

  // Unpack the flat data bus into one word per channel
  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_unpack
      assign w_ch_data[k] = din[k*WIDTH +: WIDTH];
    end
  endgenerate

  // A rising mode edge (seen against last cycle's mode) starts a new scan episode
  assign w_entry      = mode & ~r_mode_q;
  // Extra top bit keeps the compare correct when NCH == 2**SELW
  assign w_in_range   = ({1'b0, sel_in} < (SELW+1)'(NCH));
  assign w_idx        = mode ? (w_entry ? '0 : r_ptr) : sel_in;
  assign w_last_dwell = (r_dwell_cnt == LAST_CNT);
  assign w_last_ch    = (r_ptr == LAST_CH);
  // Explicit wrap so a non-power-of-two NCH never reaches an unused index
  assign w_ptr_next   = w_last_ch ? '0 : r_ptr + SELW'(1);

  // Channel data mux; an index with no matching channel yields zero
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_idx == SELW'(i)) w_sel_data = w_ch_data[i];
    end
  end

  // Previous-cycle mode, tracked regardless of enable for entry detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mode_q <= 1'b0;
    else     r_mode_q <= mode;
  end

  // Output registers: sample, channel tag, valid strobe and wrap pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_ch    <= '0;
      r_dout_valid <= 1'b0;
      r_scan_wrap  <= 1'b0;
    end else if (!en) begin
      r_dout_valid <= 1'b0;
      r_scan_wrap  <= 1'b0;
    end else if (!mode) begin
      r_dout       <= w_in_range ? w_sel_data : '0;
      r_dout_ch    <= sel_in;
      r_dout_valid <= w_in_range;
      r_scan_wrap  <= 1'b0;
    end else begin
      r_dout       <= w_sel_data;
      r_dout_ch    <= w_idx;
      r_dout_valid <= 1'b1;
      r_scan_wrap  <= ~w_entry & w_last_dwell & w_last_ch;
    end
  end

  // Scan pointer and dwell counter; entry treats the sample as channel 0, count 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_dwell_cnt <= '0;
    end else if (w_entry) begin
      if (en && DWELL == 1) begin
        r_ptr       <= SELW'(1);
        r_dwell_cnt <= '0;
      end else if (en) begin
        r_ptr       <= '0;
        r_dwell_cnt <= CNTW'(1);
      end else begin
        r_ptr       <= '0;
        r_dwell_cnt <= '0;
      end
    end else if (en && mode) begin
      if (w_last_dwell) begin
        r_dwell_cnt <= '0;
        r_ptr       <= w_ptr_next;
      end else begin
        r_dwell_cnt <= r_dwell_cnt + CNTW'(1);
      end
    end
  end

  assign dout       = r_dout;
  assign dout_ch    = r_dout_ch;
  assign dout_valid = r_dout_valid;
  assign scan_wrap  = r_scan_wrap;

endmodule

// File: tb/tb_mux_scan_n.sv
// Testbench for mux_scan_n: three configurations (4ch/dwell 2, 3ch/dwell 1,
// 5ch/dwell 3) driven by directed scenarios and then random stimulus, each
// compared every cycle with a sample-position reference model.
module tb_mux_scan_n;

  typedef struct {
    int pos;   // sample index within the current scan period
    bit mq;    // mode seen on the previous cycle
    int dout;
    int ch;
    bit vld;
    bit wrap;
  } mst_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Config A: NCH=4, WIDTH=8, SELW=2, DWELL=2
  logic [31:0] a_din;
  logic        a_mode, a_en;
  logic [1:0]  a_sel;
  logic [7:0]  a_dout;
  logic [1:0]  a_ch;
  logic        a_vld, a_wrap;
  // Config B: NCH=3, WIDTH=8, SELW=2, DWELL=1
  logic [23:0] b_din;
  logic        b_mode, b_en;
  logic [1:0]  b_sel;
  logic [7:0]  b_dout;
  logic [1:0]  b_ch;
  logic        b_vld, b_wrap;
  // Config C: NCH=5, WIDTH=4, SELW=3, DWELL=3
  logic [19:0] c_din;
  logic        c_mode, c_en;
  logic [2:0]  c_sel;
  logic [3:0]  c_dout;
  logic [2:0]  c_ch;
  logic        c_vld, c_wrap;

  mux_scan_n #(.NCH(4), .WIDTH(8), .SELW(2), .DWELL(2)) u_a (
    .clk(clk), .rst(rst), .din(a_din), .mode(a_mode), .sel_in(a_sel), .en(a_en),
    .dout(a_dout), .dout_ch(a_ch), .dout_valid(a_vld), .scan_wrap(a_wrap));

  mux_scan_n #(.NCH(3), .WIDTH(8), .SELW(2), .DWELL(1)) u_b (
    .clk(clk), .rst(rst), .din(b_din), .mode(b_mode), .sel_in(b_sel), .en(b_en),
    .dout(b_dout), .dout_ch(b_ch), .dout_valid(b_vld), .scan_wrap(b_wrap));

  mux_scan_n #(.NCH(5), .WIDTH(4), .SELW(3), .DWELL(3)) u_c (
    .clk(clk), .rst(rst), .din(c_din), .mode(c_mode), .sel_in(c_sel), .en(c_en),
    .dout(c_dout), .dout_ch(c_ch), .dout_valid(c_vld), .scan_wrap(c_wrap));

  int   n_checks = 0;
  int   n_errors = 0;
  mst_t ma, mb, mc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic mst_t model_reset();
    mst_t s;
    s = '{pos: 0, mq: 1'b0, dout: 0, ch: 0, vld: 1'b0, wrap: 1'b0};
    return s;
  endfunction

  function automatic int chan_of(input logic [63:0] d, input int k, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return int'((d >> (k * w)) & mask);
  endfunction

  // Scan position model: sample n of an episode shows channel (n / DWELL) mod NCH
  task automatic step_model(input int nch, input int dwell, input int w,
                            input logic [63:0] d, input bit mode, input bit en,
                            input int sel, inout mst_t s);
    bit entry;
    entry = mode && !s.mq;
    s.mq  = mode;
    if (!en) begin
      s.vld  = 1'b0;
      s.wrap = 1'b0;
      if (entry) s.pos = 0;
    end else if (!mode) begin
      s.ch   = sel;
      s.wrap = 1'b0;
      s.vld  = (sel < nch);
      s.dout = s.vld ? chan_of(d, sel, w) : 0;
    end else begin
      if (entry) s.pos = 0;
      s.ch   = (s.pos / dwell) % nch;
      s.dout = chan_of(d, s.ch, w);
      s.vld  = 1'b1;
      s.wrap = (s.pos == nch * dwell - 1);
      s.pos  = (s.pos + 1) % (nch * dwell);
    end
  endtask

  task automatic cmp4(input string p, input logic [31:0] d, input logic [31:0] c,
                      input logic v, input logic w, input mst_t s);
    chk({p, ".dout"}, d, 32'(s.dout));
    chk({p, ".dout_ch"}, c, 32'(s.ch));
    chk({p, ".valid"}, 32'(v), 32'(s.vld));
    chk({p, ".wrap"}, 32'(w), 32'(s.wrap));
  endtask

  // Called just after a rising edge: predict, advance one clock, compare
  task automatic tick();
    step_model(4, 2, 8, 64'(a_din), a_mode, a_en, int'(a_sel), ma);
    step_model(3, 1, 8, 64'(b_din), b_mode, b_en, int'(b_sel), mb);
    step_model(5, 3, 4, 64'(c_din), c_mode, c_en, int'(c_sel), mc);
    @(posedge clk);
    #1;
    cmp4("A", 32'(a_dout), 32'(a_ch), a_vld, a_wrap, ma);
    cmp4("B", 32'(b_dout), 32'(b_ch), b_vld, b_wrap, mb);
    cmp4("C", 32'(c_dout), 32'(c_ch), c_vld, c_wrap, mc);
  endtask

  // Pulse reset between clock edges and confirm the outputs clear at once
  task automatic mid_reset();
    rst = 1'b1;
    #1;
    chk("rst.dout", 32'(a_dout), 32'h0);
    chk("rst.dout_ch", 32'(a_ch), 32'h0);
    chk("rst.valid", 32'(a_vld), 32'h0);
    chk("rst.wrap", 32'(a_wrap), 32'h0);
    chk("rst.c_dout", 32'(c_dout), 32'h0);
    #1;
    rst = 1'b0;
    ma = model_reset();
    mb = model_reset();
    mc = model_reset();
  endtask

  logic [7:0] sweep_exp [4];
  int         a_seq [9];

  initial begin
    sweep_exp = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    a_seq     = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    rst = 1'b1;
    a_din = '0; a_mode = 1'b0; a_en = 1'b0; a_sel = '0;
    b_din = '0; b_mode = 1'b0; b_en = 1'b0; b_sel = '0;
    c_din = '0; c_mode = 1'b0; c_en = 1'b0; c_sel = '0;
    @(posedge clk);
    #1;
    chk("init.dout", 32'(a_dout), 32'h0);
    chk("init.dout_ch", 32'(a_ch), 32'h0);
    chk("init.valid", 32'(a_vld), 32'h0);
    chk("init.wrap", 32'(a_wrap), 32'h0);
    rst = 1'b0;
    ma = model_reset();
    mb = model_reset();
    mc = model_reset();

    // Manual sweep over all channels; B sees sel_in=3 out of range last
    a_din = 32'hD3C2B1A0; b_din = 24'hC2B1A0; c_din = 20'h43210;
    a_en = 1'b1; b_en = 1'b1; c_en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s); b_sel = 2'(s); c_sel = 3'(s);
      tick();
      chk("sweep.dout", 32'(a_dout), 32'(sweep_exp[s]));
      chk("sweep.dout_ch", 32'(a_ch), 32'(s));
      chk("sweep.valid", 32'(a_vld), 32'h1);
    end
    chk("oor.dout", 32'(b_dout), 32'h0);
    chk("oor.dout_ch", 32'(b_ch), 32'h3);
    chk("oor.valid", 32'(b_vld), 32'h0);

    // Scan from reset: A dwells 2 per channel, C walks 5 channels x 3
    mid_reset();
    a_mode = 1'b1; c_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i < 9) begin
        chk("scan.dout_ch", 32'(a_ch), 32'(a_seq[i]));
        chk("scan.dout", 32'(a_dout), 32'(sweep_exp[a_seq[i]]));
        chk("scan.wrap", 32'(a_wrap), 32'(i == 7));
        chk("scan.valid", 32'(a_vld), 32'h1);
      end
      chk("scan5.dout_ch", 32'(c_ch), 32'((i / 3) % 5));
      chk("scan5.wrap", 32'(c_wrap), 32'(i == 14));
    end

    // Enable gating after the first channel-1 sample
    mid_reset();
    tick(); tick(); tick();
    chk("gate.pre_ch", 32'(a_ch), 32'h1);
    a_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gate.hold_dout", 32'(a_dout), 32'hB1);
      chk("gate.valid", 32'(a_vld), 32'h0);
      chk("gate.wrap", 32'(a_wrap), 32'h0);
    end
    a_en = 1'b1;
    tick();
    chk("gate.resume_ch", 32'(a_ch), 32'h1);
    chk("gate.resume_valid", 32'(a_vld), 32'h1);
    tick();
    chk("gate.next_ch", 32'(a_ch), 32'h2);

    // Mode toggle while scanning at channel 2
    a_mode = 1'b0; a_sel = 2'd1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("toggle.man_dout", 32'(a_dout), 32'hB1);
      chk("toggle.man_ch", 32'(a_ch), 32'h1);
    end
    a_mode = 1'b1;
    tick();
    chk("toggle.re0_ch", 32'(a_ch), 32'h0);
    tick();
    chk("toggle.re1_ch", 32'(a_ch), 32'h0);
    tick();
    chk("toggle.re2_ch", 32'(a_ch), 32'h1);

    // Random phase against the reference model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) mid_reset();
      a_din = $urandom; b_din = 24'($urandom); c_din = 20'($urandom);
      a_en = ($urandom_range(0, 5) != 0);
      b_en = ($urandom_range(0, 5) != 0);
      c_en = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 15) == 0) a_mode = ~a_mode;
      if ($urandom_range(0, 15) == 0) b_mode = ~b_mode;
      if ($urandom_range(0, 15) == 0) c_mode = ~c_mode;
      a_sel = 2'($urandom); b_sel = 2'($urandom); c_sel = 3'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with a registered output. It generalises the 4:1 single-bit mux.
- Two modes:
  - Manual: the channel is taken from the select input.
  - Scan: an internal round-robin pointer visits every channel, staying DWELL cycles on each.
- Used as a data-path selector or sample sequencer in front of downstream capture logic.
- Output is tagged with its channel number, a valid strobe, and a wrap pulse.

Parameters:
- NCH, 4: number of input channels, minimum 2.
- WIDTH, 8: data width per channel, minimum 1.
- SELW, 2: select/pointer width. Must satisfy 2**SELW >= NCH.
- DWELL, 4: cycles spent on each channel in scan mode, minimum 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- din  input  NCH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- mode  input  1  0 = manual, 1 = scan.
- sel_in  input  SELW  channel select in manual mode; ignored in scan mode.
- en  input  1  enable. When 0, the block holds state.
- dout  output  WIDTH  registered selected data.
- dout_ch  output  SELW  channel index that produced dout.
- dout_valid  output  1  dout/dout_ch updated this cycle.
- scan_wrap  output  1  one-cycle pulse on the last dwell sample of channel NCH-1 in scan mode.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous, active-high.
- Reset (immediate, independent of clk):
  - Outputs: dout=0, dout_ch=0, dout_valid=0, scan_wrap=0.
  - Internal state: ptr=0, dwell_cnt=0, mode_q=0.
- Latency: all outputs are registered, one cycle after the sampled inputs. No combinational path from inputs to outputs.
- Effective channel each enabled cycle:
  - Manual mode: sel_in.
  - Scan mode: ptr. On a scan-entry cycle, channel 0 regardless of ptr.
- en=0:
  - dout and dout_ch hold.
  - dout_valid <= 0 and scan_wrap <= 0.
  - ptr and dwell_cnt freeze.
  - mode_q still tracks mode.
- Manual mode (mode=0, en=1):
  - sel_in < NCH: dout <= din[sel_in], dout_ch <= sel_in, dout_valid <= 1.
  - sel_in >= NCH (out of range): dout <= 0, dout_ch <= sel_in, dout_valid <= 0.
  - scan_wrap <= 0. ptr and dwell_cnt hold.
- Scan mode (mode=1, en=1):
  - dout <= din[ptr], dout_ch <= ptr, dout_valid <= 1.
  - If dwell_cnt == DWELL-1:
    - dwell_cnt <= 0.
    - ptr <= (ptr == NCH-1) ? 0 : ptr+1.
    - scan_wrap <= (ptr == NCH-1).
  - Otherwise: dwell_cnt <= dwell_cnt+1, scan_wrap <= 0.
  - DWELL=1: ptr advances every enabled cycle.
- Scan entry:
  - mode_q registers mode every cycle.
  - A cycle with mode=1 and mode_q=0 is a scan-entry cycle, whether or not en=1.
  - On an enabled scan-entry cycle: the sample is channel 0, dwell_cnt <= 1 (or ptr <= 1 and dwell_cnt <= 0 when DWELL=1), scan_wrap <= 0.
  - On a disabled scan-entry cycle: ptr <= 0 and dwell_cnt <= 0.
  - Net effect: every scan episode starts at channel 0 with a full dwell.
- Scan exit (1 -> 0): manual selection applies from that same cycle. ptr and dwell_cnt are retained but irrelevant because re-entry resets them.
- Pointer range: ptr never exceeds NCH-1, including when NCH is not a power of two. Wrap is explicit, never a modulo-2**SELW overflow.
- Simultaneous events:
  - rst dominates all inputs.
  - en=0 dominates mode and sel_in changes for output registers only.
- Reset mid-operation: outputs clear asynchronously. The first sample after release follows the mode rules above. A scan after reset starts at channel 0.

Test Plan:
- Reset: assert rst mid-scan with outputs nonzero -> dout=0, dout_ch=0, dout_valid=0, scan_wrap=0 before the next clk edge.
- Manual sweep: NCH=4, WIDTH=8, din={8'hD3,8'hC2,8'hB1,8'hA0}, en=1, mode=0, sel_in=0,1,2,3 -> dout=A0,B1,C2,D3 one cycle later, dout_ch=0..3, dout_valid=1 each cycle.
- Out-of-range: NCH=3, SELW=2, sel_in=3 -> dout=0, dout_ch=3, dout_valid=0.
- Scan: DWELL=2, NCH=4, mode=1 from reset -> dout_ch sequence 0,0,1,1,2,2,3,3,0. scan_wrap=1 only on the second channel-3 sample, i.e. 8th valid output.
- Enable gating: scan, deassert en for 3 cycles after the first ch1 sample -> dout holds B1, dout_valid=0, scan_wrap=0. Resumes with the second ch1 sample; the sequence is not skipped.
- Mode toggle: scan running at ch2, switch mode=0 (sel_in=1) for 2 cycles then back to 1 -> two B1 samples, then scan restarts at dout_ch=0 with a full dwell. NCH=5 run confirms ptr wraps 4 -> 0.
